// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory_if initiator.
//   state_e          : initiator FSM states (IDLE / ACCESS / DONE)
//   DEF_*            : default bus geometry and timeout
//   addr_in_range()  : local address check against the populated word count
package mem_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_MEM_SIZE   = 16;
    localparam int unsigned DEF_TIMEOUT    = 15;

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned mem_size);
        return (addr < mem_size);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access-cycle counter for the memory_if initiator.
//   clk_i, reset_ni : clock, async active-low reset
//   clear_i         : force count to zero (has priority over enable_i)
//   enable_i        : count one more access cycle (saturates at TIMEOUT)
//   expired_o       : the current cycle is the TIMEOUT-th access cycle, so a
//                     missing response at the next edge ends the access
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of completed access cycles, so the TIMEOUT-th
    // cycle is the one where cnt_q == TIMEOUT-1.
    assign expired_o = (cnt_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_initiator.sv
// Initiator end of memory_if: one outstanding single-beat command at a time.
//   clk_i, reset_ni          : clock, async active-low reset
//   cmd_valid_i/cmd_ready_o  : client command handshake
//   cmd_wr_i, cmd_addr_i,
//   cmd_wdata_i              : command (1 = write), address, write data
//   rsp_valid_o              : one-cycle completion pulse
//   rsp_err_o                : timeout or out-of-range, qualifies rsp_valid_o
//   rsp_rdata_o              : read data (reads without error)
//   mem_wr_o, mem_rd_o,
//   mem_addr_o, mem_wdata_o  : memory_if strobes, address and write data
//   mem_rdata_i,
//   mem_response_i           : memory_if read data and transfer-complete
//
// state  | meaning
// IDLE   | ready for a command, bus strobes low
// ACCESS | one strobe held high, waiting for response or timeout
// DONE   | rsp_valid pulse, bus idle for one cycle before next command
module mem_bus_initiator
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MEM_SIZE   = DEF_MEM_SIZE,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic                  rsp_err_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  mem_wr_o,
    output logic                  mem_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_response_i
);

    state_e                  state_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    cmd_ready_q;
    logic                    mem_wr_q;
    logic                    mem_rd_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    expired;
    logic                    in_range;

    assign in_range = addr_in_range(32'(cmd_addr_i), MEM_SIZE);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .clear_i   (state_q != ST_ACCESS),
        .enable_i  (state_q == ST_ACCESS),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    // cmd_ready stays low for the first cycle after reset
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid_i && cmd_ready_q) begin
                        wr_q        <= cmd_wr_i;
                        addr_q      <= cmd_addr_i;
                        wdata_q     <= cmd_wdata_i;
                        cmd_ready_q <= 1'b0;
                        if (in_range) begin
                            state_q  <= ST_ACCESS;
                            mem_wr_q <= cmd_wr_i;
                            mem_rd_q <= !cmd_wr_i;
                        end else begin
                            // rejected locally: never touches the bus
                            state_q     <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end

                ST_ACCESS: begin
                    // response wins over a simultaneous timeout
                    if (mem_response_i) begin
                        state_q     <= ST_DONE;
                        mem_wr_q    <= 1'b0;
                        mem_rd_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= wr_q ? '0 : mem_rdata_i;
                    end else if (expired) begin
                        state_q     <= ST_DONE;
                        mem_wr_q    <= 1'b0;
                        mem_rd_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end

                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    mem_wr_q    <= 1'b0;
                    mem_rd_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    cmd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
module tb_mem_bus_initiator;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_wr;
    logic        mem_rd;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_response;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int g_first;
    int g_last;

    logic [31:0] mem_model [16];

    logic        nxt_wr;
    logic [3:0]  nxt_addr;
    logic [31:0] nxt_wdata;

    localparam logic [31:0] IDLE_RDATA = 32'hA5A5_5A5A;

    mem_bus_initiator #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (32),
        .MEM_SIZE   (12),
        .TIMEOUT    (15)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_wr_i       (cmd_wr),
        .cmd_addr_i     (cmd_addr),
        .cmd_wdata_i    (cmd_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_err_o      (rsp_err),
        .rsp_rdata_o    (rsp_rdata),
        .mem_wr_o       (mem_wr),
        .mem_rd_o       (mem_rd),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .mem_response_i (mem_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command, plays the responder (answers in access cycle
    // resp_at, 0 = silent) and checks the completion plus the cycle after it.
    task automatic do_txn(input string tag, input logic wr, input logic [3:0] addr,
                          input logic [31:0] wdata, input int resp_at, input logic hold_next,
                          input logic exp_err, input logic [31:0] exp_rdata, input int exp_strobes);
        logic        accepted = 1'b0;
        logic        done = 1'b0;
        logic        acc_now;
        logic        got_err = 1'b0;
        logic [31:0] got_rdata = '0;
        int lat = 0;
        int strobes = 0;
        int bad_bus = 0;
        int bad_ready = 0;
        g_first = -1;
        g_last = -1;
        cmd_valid = 1'b1;
        cmd_wr = wr;
        cmd_addr = addr;
        cmd_wdata = wdata;
        mem_response = 1'b0;
        mem_rdata = IDLE_RDATA;
        for (int it = 0; it < 60 && !done; it++) begin
            acc_now = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            mem_response = 1'b0;
            mem_rdata = IDLE_RDATA;
            if (acc_now && !accepted) begin
                accepted = 1'b1;
                if (hold_next) begin
                    cmd_wr = nxt_wr;
                    cmd_addr = nxt_addr;
                    cmd_wdata = nxt_wdata;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (accepted) begin
                lat++;
                if (mem_wr || mem_rd) begin
                    strobes++;
                    if (g_first < 0) g_first = cyc;
                    g_last = cyc;
                    if (mem_wr != wr || mem_rd != !wr || mem_addr != addr ||
                        (wr && mem_wdata != wdata))
                        bad_bus++;
                    if (strobes == resp_at) begin
                        mem_response = 1'b1;
                        if (wr) mem_model[addr] = wdata;
                        else mem_rdata = mem_model[addr];
                    end
                end
                if (rsp_valid) begin
                    done = 1'b1;
                    got_err = rsp_err;
                    got_rdata = rsp_rdata;
                end else if (cmd_ready) begin
                    bad_ready++;
                end
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (done) begin
            check({tag, "_err"}, 32'(got_err), 32'(exp_err));
            if (!wr || exp_err) check({tag, "_rdata"}, got_rdata, exp_rdata);
            check({tag, "_strobes"}, 32'(strobes), 32'(exp_strobes));
            check({tag, "_latency"}, 32'(lat), 32'(exp_strobes + 1));
            check({tag, "_bus"}, 32'(bad_bus), 32'd0);
            check({tag, "_busy_ready"}, 32'(bad_ready), 32'd0);
            @(posedge clk);
            #1;
            check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
            check({tag, "_post_strobe"}, 32'({mem_wr, mem_rd}), 32'd0);
            check({tag, "_post_ready"}, 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        int last1;
        int seen;
        for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        mem_rdata = IDLE_RDATA;
        mem_response = 1'b0;
        nxt_wr = 1'b0;
        nxt_addr = '0;
        nxt_wdata = '0;

        #2;
        check("rst_outputs", {24'd0, cmd_ready, rsp_valid, rsp_err, mem_wr, mem_rd, 3'd0}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_addr", {28'd0, mem_addr}, 32'd0);
        #20;
        reset_n = 1'b1;
        #1;
        check("rst_ready_before_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst_ready_after_edge", 32'(cmd_ready), 32'd1);

        do_txn("wr3", 1'b1, 4'd3, 32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h0, 2);
        do_txn("rd3", 1'b0, 4'd3, 32'h0, 1, 1'b0, 1'b0, 32'hDEADBEEF, 1);
        do_txn("rd7_timeout", 1'b0, 4'd7, 32'h0, 0, 1'b0, 1'b1, 32'h0, 15);
        do_txn("wr13_range", 1'b1, 4'd13, 32'h1111_2222, 0, 1'b0, 1'b1, 32'h0, 0);
        do_txn("rd12_range", 1'b0, 4'd12, 32'h0, 0, 1'b0, 1'b1, 32'h0, 0);
        do_txn("wr11", 1'b1, 4'd11, 32'hCAFE_F00D, 3, 1'b0, 1'b0, 32'h0, 3);
        do_txn("rd11", 1'b0, 4'd11, 32'h0, 1, 1'b0, 1'b0, 32'hCAFE_F00D, 1);

        nxt_wr = 1'b0;
        nxt_addr = 4'd5;
        nxt_wdata = 32'h0;
        do_txn("b2b_wr", 1'b1, 4'd5, 32'h1234_5678, 1, 1'b1, 1'b0, 32'h0, 1);
        last1 = g_last;
        do_txn("b2b_rd", 1'b0, 4'd5, 32'h0, 2, 1'b0, 1'b0, 32'h1234_5678, 2);
        check("b2b_gap", 32'(g_first - last1 - 1), 32'd2);

        // stray response while idle must not start anything
        mem_response = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || mem_wr || mem_rd || !cmd_ready) seen++;
        end
        mem_response = 1'b0;
        check("idle_response_ignored", 32'(seen), 32'd0);

        // reset in the middle of an access
        cmd_valid = 1'b1;
        cmd_wr = 1'b1;
        cmd_addr = 4'd2;
        cmd_wdata = 32'h5555_AAAA;
        seen = 0;
        for (int i = 0; i < 5 && !mem_wr; i++) begin
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("mid_rst_strobe_up", 32'(mem_wr), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_strobes_low", 32'({mem_wr, mem_rd}), 32'd0);
        check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || mem_wr || mem_rd) seen++;
        end
        check("mid_rst_quiet_after", 32'(seen), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        do_txn("rd3_after_rst", 1'b0, 4'd3, 32'h0, 1, 1'b0, 1'b0, 32'hDEADBEEF, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
